// File: rtl/riscy_pkg.sv
// Shared fetch-path types: the queued fetch entry and the idle (NOP) head value.
package riscy_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred_taken;
  } fetch_entry_t;

  localparam fetch_entry_t IDLE_ENTRY = '{instr: NOP_INSTR, pc: 32'h0, pred_taken: 1'b0};

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for fetch_buffer: DEPTH registers, one synchronous write port,
// one asynchronous read port, no reset (contents survive flush and reset).
module fetch_buffer_mem
  import riscy_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fetch_entry_t rd_data
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// In-order decoupling queue between fetch and decode with flush on mispredict.
// Optional same-cycle empty-buffer bypass enabled by defining FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
  import riscy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       req,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [31:0]                instr_in,
  input  logic [31:0]                pc_in,
  input  logic                       branch_predicted_taken_in,
  output logic                       ready_out,
  input  logic                       flush_in,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic                       branch_predicted_taken_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  fetch_entry_t in_entry, head_entry, out_entry;
  logic empty, bypass, push, pop;

  fetch_buffer_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk    (req),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data(in_entry),
    .rd_addr(rd_ptr_q),
    .rd_data(head_entry)
  );

  always_comb begin
    in_entry = '{instr: instr_in, pc: pc_in, pred_taken: branch_predicted_taken_in};
    empty    = (count_q == '0);
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass   = empty && valid_in && !flush_in && !reset;
`else
    bypass   = 1'b0;
`endif
    ready_out = (count_q < FULL_COUNT) && !reset;
    valid_out = (!empty || bypass) && !flush_in && !reset;

    // A bypassed entry consumed in the same cycle never touches the storage.
    pop  = valid_out && ready_in && !empty;
    push = valid_in && ready_out && !flush_in && !(bypass && ready_in);

    out_entry = IDLE_ENTRY;
    if (valid_out) out_entry = bypass ? in_entry : head_entry;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  assign instr_out                  = out_entry.instr;
  assign pc_out                     = out_entry.pc;
  assign branch_predicted_taken_out = out_entry.pred_taken;
  assign count_out                  = count_q;

  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue-based reference model predicts each
// handshake, a separate monitor checks what decode actually receives.
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
  } ent_t;

  logic        req = 1'b0;
  logic        reset;
  logic        valid_in, flush_in, ready_in, branch_predicted_taken_in;
  logic [31:0] instr_in, pc_in;
  logic        ready_out, valid_out, branch_predicted_taken_out;
  logic [31:0] instr_out, pc_out;
  logic [$clog2(DEPTH+1)-1:0] count_out;

  int checks   = 0;
  int failures = 0;

  ent_t model[$];
  ent_t exp_q[$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .req                       (req),
    .reset                     (reset),
    .valid_in                  (valid_in),
    .instr_in                  (instr_in),
    .pc_in                     (pc_in),
    .branch_predicted_taken_in (branch_predicted_taken_in),
    .ready_out                 (ready_out),
    .flush_in                  (flush_in),
    .ready_in                  (ready_in),
    .valid_out                 (valid_out),
    .instr_out                 (instr_out),
    .pc_out                    (pc_out),
    .branch_predicted_taken_out(branch_predicted_taken_out),
    .count_out                 (count_out)
  );

  always #5 req = ~req;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input logic exp_valid, input logic exp_ready, input int exp_count);
    checkEq("valid_out", 32'(valid_out), 32'(exp_valid));
    checkEq("ready_out", 32'(ready_out), 32'(exp_ready));
    checkEq("count_out", 32'(count_out), 32'(exp_count));
  endtask

  // One cycle: drive at the falling edge, predict, check, then advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                               input logic pt, input logic rdy, input logic fl);
    int   sz;
    logic byp, expv, took, accept;
    ent_t e;
    @(negedge req);
    valid_in = v; instr_in = ins; pc_in = p; branch_predicted_taken_in = pt;
    ready_in = rdy; flush_in = fl;
    e.instr = ins; e.pc = p; e.pt = pt;
    sz  = model.size();
    byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
    byp = (sz == 0) && v && !fl;
`endif
    expv = !fl && (sz > 0 || byp);
    if (expv && rdy) exp_q.push_back(sz > 0 ? model[0] : e);
    #1;
    checkOutput(expv, sz < DEPTH, sz);
    if (fl) begin
      model.delete();
    end else begin
      took   = expv && rdy;
      accept = v && (sz < DEPTH);
      if (took && sz > 0) void'(model.pop_front());
      if (accept && !(took && sz == 0)) model.push_back(e);
    end
  endtask

  task automatic applyReset();
    @(negedge req);
    reset = 1'b1;
    valid_in = 1'b1; instr_in = $urandom; pc_in = $urandom; ready_in = 1'b1; flush_in = 1'b0;
    #1;
    checkOutput(1'b0, 1'b0, 0);
    checkEq("reset_instr", instr_out, 32'h0000_0013);
    checkEq("reset_pc", pc_out, 32'h0);
    checkEq("reset_pt", 32'(branch_predicted_taken_out), 32'h0);
    model.delete();
    exp_q.delete();
    @(negedge req);
    reset = 1'b0;
    valid_in = 1'b0; ready_in = 1'b0;
    #1;
    checkEq("ready_after_reset", 32'(ready_out), 32'h1);
  endtask

  // Monitor: every consumed head entry must match the oldest predicted one.
  initial begin
    ent_t e;
    forever begin
      @(negedge req);
      #2;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pop actual=pc %h required=no entry at %0t", pc_out, $time);
        end else begin
          e = exp_q.pop_front();
          checkEq("instr_out", instr_out, e.instr);
          checkEq("pc_out", pc_out, e.pc);
          checkEq("pred_out", 32'(branch_predicted_taken_out), 32'(e.pt));
        end
      end else if (!valid_out) begin
        checkEq("idle_instr", instr_out, 32'h0000_0013);
        checkEq("idle_pc", pc_out, 32'h0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    valid_in = 1'b0; instr_in = '0; pc_in = '0; branch_predicted_taken_in = 1'b0;
    ready_in = 1'b0; flush_in = 1'b0;
    applyReset();

    applyStimulus(1'b1, 32'h0010_0093, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h1000 + 32'(i), 32'(i * 4), i[0], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 32'h2000 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++)
      applyStimulus(1'b1, 32'h2000 + 32'(i), 32'h100 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h3000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h20C, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h0020_8133, 32'h300, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) applyReset();
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    @(negedge req);
    #3;
    checkEq("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Decoupling instruction queue between `fetch` and `decode`. It accepts {instruction, PC, predicted-taken} entries from fetch, holds up to DEPTH of them, and presents them in order to decode. This absorbs decode stalls without throttling instruction-RAM requests. On a branch misprediction it discards every queued entry, so wrong-path instructions never reach decode.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2

Ports:
- req  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- valid_in  input  1  fetch presents an entry
- instr_in  input  32  instruction word from fetch
- pc_in  input  32  PC of instr_in
- branch_predicted_taken_in  input  1  fetch prediction for instr_in
- ready_out  output  1  buffer accepts an entry this cycle
- flush_in  input  1  branch mispredicted; drop all entries
- ready_in  input  1  decode consumes the head entry this cycle
- valid_out  output  1  head entry is valid
- instr_out  output  32  head instruction; NOP 32'h0000_0013 when not valid
- pc_out  output  32  head PC; 0 when not valid
- branch_predicted_taken_out  output  1  head prediction; 0 when not valid
- count_out  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Push:
  - Occurs when valid_in && ready_out && !flush_in.
  - Writes the entry at wr_ptr, then wr_ptr++.
- Pop:
  - Occurs when valid_out && ready_in && !flush_in.
  - Advances rd_ptr.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count updates per edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Flow control:
  - ready_out = (count < DEPTH) && !reset.
  - When full, no push is accepted even if a pop occurs in the same cycle (no pass-through on full).
- Flush:
  - At the next edge, count, wr_ptr and rd_ptr go to 0.
  - Any push or pop offered in the flush cycle is ignored.
  - valid_out is forced to 0 combinationally while flush_in = 1.
- While valid_out = 0, the data outputs are held at their idle values (NOP, 0, 0), not stale memory contents.
- Entry storage is not cleared on flush or reset; only pointers and count are.

## Timing
- Reset, asynchronous: count_out=0, valid_out=0, ready_out=0, instr_out=32'h0000_0013, pc_out=0, branch_predicted_taken_out=0.
- ready_out rises combinationally once reset is released.
- Latency, base build: an entry pushed at edge N appears on valid_out/instr_out in the cycle after edge N (1 cycle).
- Throughput: one push and one pop per cycle sustained; the buffer never stalls fetch unless it is full.
- Head outputs are read combinationally from the register at rd_ptr. Registered state is limited to count, pointers and storage.
- Reset mid-operation: all in-flight entries are lost and outputs return to their reset values immediately.
- Flush and reset take priority over push and pop. Reset takes priority over flush.

## Configuration
- FETCH_BUFFER_BYPASS_EN undefined:
  - Behaviour as above.
  - Minimum latency is 1 cycle.
- FETCH_BUFFER_BYPASS_EN defined, and the buffer is empty with valid_in=1 and flush_in=0:
  - valid_out=1 and the head outputs show instr_in/pc_in/branch_predicted_taken_in in the same cycle.
  - If ready_in=1, the entry is consumed without being written: pointers and count are unchanged.
  - If ready_in=0, the entry is written normally.
- The bypass never applies when count > 0, which preserves ordering.

## Structure
- Shared package `riscy_pkg`:
  - `fetch_entry_t` packed struct {instr[31:0], pc[31:0], pred_taken}.
  - `NOP_INSTR` = 32'h0000_0013.
- One sub-module, `fetch_buffer_mem`:
  - DEPTH × fetch_entry_t register array.
  - One synchronous write port and one asynchronous read port.
  - No reset.
- Pointer/count control and output muxing live in `fetch_buffer`.

## Test plan
- Reset → valid_out=0, ready_out=0, instr_out=32'h0000_0013, count_out=0. Release reset → ready_out=1.
- Push 0x00100093 @ pc 0x0 with ready_in=0 → next cycle valid_out=1, instr_out=0x00100093, pc_out=0, count_out=1.
- Push 4 entries (pc 0,4,8,C) with ready_in=0 → count_out=4 and ready_out=0. A 5th valid_in is not accepted. Then ready_in=1 for 4 cycles → pcs 0,4,8,C in order, then valid_out=0.
- Continuous push+pop at count=2 for 10 cycles, through pointer wrap → count_out stays 2 and the pc sequence increments by 4 with no gaps.
- Count=3 with flush_in=1 and valid_in=1 in the same cycle → valid_out=0 in that cycle and count_out=0 next cycle. The flush-cycle entry never appears at the output.
- FETCH_BUFFER_BYPASS_EN defined, empty buffer, valid_in=1 with instr 0x00208133, ready_in=1 → instr_out=0x00208133 in the same cycle, and count_out stays 0.
